jtag_tap: RTL

Debug-port front end for the processor. It sits between the chassis GPIO JTAG pins (TCK/TDI/TDO/TMS) and the processor core's debug logic. It oversamples the JTAG pins with the system clock, runs the IEEE 1149.1 16-state TAP controller, and implements a 4-bit instruction register with IDCODE, DATA and BYPASS data registers. DATA transfers are presented to the core as a single-cycle command strobe plus a captured status word.

---
 rtl/jtag_tap.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/jtag_tap.sv
// JTAG debug-port front end: oversamples the raw TCK/TDI/TMS pins on the system
// clock, runs the 16-state TAP controller and the IR/IDCODE/DATA/BYPASS registers.
module jtag_tap #(
   parameter int                  DR_WIDTH = 16,
   parameter logic [DR_WIDTH-1:0] IDCODE   = 16'h52C5
) (
   input  logic                jtag_clk,
   input  logic                jtag_rst,
   input  logic                jtag_tck,
   input  logic                jtag_tdi,
   input  logic                jtag_tms,
   output logic                jtag_tdo,
   output logic                jtag_tdoEn,
   input  logic [DR_WIDTH-1:0] jtag_capWord,
   output logic [DR_WIDTH-1:0] jtag_cmdWord,
   output logic                jtag_cmdValid,
   output logic                jtag_tlr,
   output logic [3:0]          jtag_state
);

   typedef enum logic [3:0] {
      TLR    = 4'd0,  RTI    = 4'd1,
      SEL_DR = 4'd2,  CAP_DR = 4'd3,  SH_DR  = 4'd4,  EX1_DR = 4'd5,
      PAU_DR = 4'd6,  EX2_DR = 4'd7,  UPD_DR = 4'd8,
      SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11, EX1_IR = 4'd12,
      PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
   } tap_state_t;

   typedef enum logic [1:0] {SEL_IDCODE, SEL_DATA, SEL_BYPASS} dr_sel_t;

   localparam logic [3:0] IR_IDCODE  = 4'b0001;
   localparam logic [3:0] IR_DATA    = 4'b0010;
   localparam logic [3:0] IR_BYPASS  = 4'b1111;
   localparam logic [3:0] IR_CAPTURE = 4'b0101;

   logic tck_s1, tck_s2, tck_s3;
   logic tdi_s1, tdi_s2;
   logic tms_s1, tms_s2;
   logic tck_rise, tck_fall;

   tap_state_t state, state_nxt;
   dr_sel_t    dr_sel;

   logic [3:0]          ir, ir_sh;
   logic [DR_WIDTH-1:0] dr_sh;
   logic                byp;
   logic                tdo;
   logic [DR_WIDTH-1:0] cmd_word;
   logic                cmd_valid;

   // Two flops per pin for metastability; the third TCK flop gives the edge detect.
   always_ff @(posedge jtag_clk) begin
      if (jtag_rst) begin
         tck_s1 <= 1'b0; tck_s2 <= 1'b0; tck_s3 <= 1'b0;
         tdi_s1 <= 1'b0; tdi_s2 <= 1'b0;
         tms_s1 <= 1'b0; tms_s2 <= 1'b0;
      end else begin
         tck_s1 <= jtag_tck; tck_s2 <= tck_s1; tck_s3 <= tck_s2;
         tdi_s1 <= jtag_tdi; tdi_s2 <= tdi_s1;
         tms_s1 <= jtag_tms; tms_s2 <= tms_s1;
      end
   end

   assign tck_rise = tck_s2 & ~tck_s3;
   assign tck_fall = ~tck_s2 & tck_s3;

   always_ff @(posedge jtag_clk) begin
      if (jtag_rst)      state <= TLR;
      else if (tck_rise) state <= state_nxt;
   end

   // NOTE: defaults first so every path assigns state_nxt and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         TLR:    state_nxt = tms_s2 ? TLR    : RTI;
         RTI:    state_nxt = tms_s2 ? SEL_DR : RTI;
         SEL_DR: state_nxt = tms_s2 ? SEL_IR : CAP_DR;
         CAP_DR: state_nxt = tms_s2 ? EX1_DR : SH_DR;
         SH_DR:  state_nxt = tms_s2 ? EX1_DR : SH_DR;
         EX1_DR: state_nxt = tms_s2 ? UPD_DR : PAU_DR;
         PAU_DR: state_nxt = tms_s2 ? EX2_DR : PAU_DR;
         EX2_DR: state_nxt = tms_s2 ? UPD_DR : SH_DR;
         UPD_DR: state_nxt = tms_s2 ? SEL_DR : RTI;
         SEL_IR: state_nxt = tms_s2 ? TLR    : CAP_IR;
         CAP_IR: state_nxt = tms_s2 ? EX1_IR : SH_IR;
         SH_IR:  state_nxt = tms_s2 ? EX1_IR : SH_IR;
         EX1_IR: state_nxt = tms_s2 ? UPD_IR : PAU_IR;
         PAU_IR: state_nxt = tms_s2 ? EX2_IR : PAU_IR;
         EX2_IR: state_nxt = tms_s2 ? UPD_IR : SH_IR;
         UPD_IR: state_nxt = tms_s2 ? SEL_DR : RTI;
         default: state_nxt = TLR;
      endcase
   end

   always_comb begin
      dr_sel = SEL_BYPASS;
      case (ir)
         IR_IDCODE: dr_sel = SEL_IDCODE;
         IR_DATA:   dr_sel = SEL_DATA;
         IR_BYPASS: dr_sel = SEL_BYPASS;
         default:   dr_sel = SEL_BYPASS;
      endcase
   end

   // Capture and update act on the rise that enters the state; shifting acts on
   // every rise taken while sitting in a shift state.
   always_ff @(posedge jtag_clk) begin
      if (jtag_rst) begin
         ir        <= IR_IDCODE;
         ir_sh     <= '0;
         dr_sh     <= '0;
         byp       <= 1'b0;
         tdo       <= 1'b0;
         cmd_word  <= '0;
         cmd_valid <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         if (tck_rise) begin
            if (state_nxt == CAP_IR) ir_sh <= IR_CAPTURE;
            if (state == SH_IR)      ir_sh <= {tdi_s2, ir_sh[3:1]};
            if (state_nxt == UPD_IR) ir <= ir_sh;
            if (state_nxt == TLR)    ir <= IR_IDCODE;

            if (state_nxt == CAP_DR) begin
               case (dr_sel)
                  SEL_IDCODE: dr_sh <= IDCODE;
                  SEL_DATA:   dr_sh <= jtag_capWord;
                  default:    byp   <= 1'b0;
               endcase
            end
            if (state == SH_DR) begin
               if (dr_sel == SEL_BYPASS) byp   <= tdi_s2;
               else                      dr_sh <= {tdi_s2, dr_sh[DR_WIDTH-1:1]};
            end
            if (state_nxt == UPD_DR && dr_sel == SEL_DATA) begin
               cmd_word  <= dr_sh;
               cmd_valid <= 1'b1;
            end
         end

         // TDO changes on the falling TCK so the host samples a stable bit on the rise.
         if (tck_fall) begin
            if (state == SH_IR)      tdo <= ir_sh[0];
            else if (state == SH_DR) tdo <= (dr_sel == SEL_BYPASS) ? byp : dr_sh[0];
            else                     tdo <= 1'b0;
         end
      end
   end

   assign jtag_tdo      = tdo;
   assign jtag_tdoEn    = (state == SH_DR) | (state == SH_IR);
   assign jtag_cmdWord  = cmd_word;
   assign jtag_cmdValid = cmd_valid;
   assign jtag_tlr      = (state == TLR);
   assign jtag_state    = state;

endmodule
